// File: rtl/vram_rr_sched.sv
// Round-robin scheduler for the shared 32-bit VRAM read path; the CPU port (cpu_busy) always wins.
// Define VRAM_SCHED_STARVE_GUARD_EN to add per-requester wait counters that raise cpu_hold.
module vram_rr_sched #(
  parameter int NUM_REQ  = 3,
  parameter int AW       = 15,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_busy,
  output logic                  cpu_hold,
  input  logic [NUM_REQ-1:0]    req_strobe,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [31:0]           req_rddata,
  output logic [AW-1:0]         ram_addr,
  output logic                  ram_strobe,
  input  logic [31:0]           ram_rddata
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      rr_ptr;
  logic               gnt_vld_p0;
  logic [PW-1:0]      win_p0;
  logic [NUM_REQ-1:0] gnt_oh_p0;

  // Stage p0: combinational scan starting at rr_ptr; reset and the CPU both block any grant
  always_comb begin
    gnt_vld_p0 = 1'b0;
    win_p0     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_vld_p0 && req_strobe[idx]) begin
        gnt_vld_p0 = 1'b1;
        win_p0     = PW'(idx);
      end
    end
    if (cpu_busy || !rst_n) begin
      gnt_vld_p0 = 1'b0;
      win_p0     = '0;
    end
  end

  assign gnt_oh_p0  = gnt_vld_p0 ? (NUM_REQ'(1) << win_p0) : '0;
  assign ram_strobe = gnt_vld_p0;
  assign ram_addr   = gnt_vld_p0 ? req_addr[int'(win_p0)*AW +: AW] : '0;

  // Stage p1: ack lines up with the RAM's one-cycle read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ack <= '0;
      rr_ptr  <= '0;
    end else begin
      req_ack <= gnt_oh_p0;
      if (gnt_vld_p0)
        rr_ptr <= (win_p0 == PW'(NUM_REQ - 1)) ? '0 : win_p0 + 1'b1;
    end
  end

  assign req_rddata = ram_rddata;

`ifdef VRAM_SCHED_STARVE_GUARD_EN
  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [WW-1:0] wait_cnt  [NUM_REQ];
  logic [WW-1:0] wait_next [NUM_REQ];
  logic          starved;

  // Hold follows the next counter values so it drops right after the starved grant
  always_comb begin
    starved = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_strobe[i] || gnt_oh_p0[i])
        wait_next[i] = '0;
      else if (wait_cnt[i] != WW'(MAX_WAIT))
        wait_next[i] = wait_cnt[i] + 1'b1;
      else
        wait_next[i] = wait_cnt[i];
      if (wait_next[i] >= WW'(MAX_WAIT))
        starved = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_hold <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
    end else begin
      cpu_hold <= starved;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= wait_next[i];
    end
  end
`else
  // Guard compiled out: the threshold has no effect and hold stays low
  localparam bit HOLD_TIE = (MAX_WAIT < 0);
  assign cpu_hold = HOLD_TIE;
`endif

endmodule

// File: doc/vram_rr_sched.md
Name: vram_rr_sched

Overview:
- Round-robin scheduler sharing the 32-bit VRAM read path (32k x 32 main RAM) between NUM_REQ renderer fetch units (layers, sprites).
- The CPU 8-bit port keeps absolute priority and is signalled to this block through cpu_busy.
- Drives one address/strobe into the RAM, returns a per-requester ack one cycle later, and broadcasts read data.
- Optional starvation guard can throttle the CPU port.

Parameters:
- NUM_REQ, 3, number of 32-bit read requesters (2..8).
- AW, 15, word address width.
- MAX_WAIT, 15, starvation threshold in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_busy  in  1  CPU port owns the RAM this cycle (CPU strobe)
- cpu_hold  out  1  request that the CPU defer its next access (starvation guard)
- req_strobe  in  NUM_REQ  per-requester request, held until ack
- req_addr  in  NUM_REQ*AW  packed word addresses; requester i uses bits [i*AW +: AW]
- req_ack  out  NUM_REQ  one-hot, high one cycle after grant; data valid that cycle
- req_rddata  out  32  read data broadcast to all requesters
- ram_addr  out  AW  RAM word address (combinational)
- ram_strobe  out  1  RAM read issued this cycle (combinational)
- ram_rddata  in  32  RAM read data, 1-cycle latency

Behaviour:
- Reset (async, rst_n=0):
  - req_ack=0, rr_ptr=0, grant_r=0, cpu_hold=0, wait counters=0.
  - ram_strobe=0 and ram_addr=0 while no request is active.
- Arbitration (combinational, every cycle):
  - If cpu_busy=1: no grant, ram_strobe=0, ram_addr=0.
  - Else: scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ. The first i with req_strobe[i]=1 wins.
  - On a win: ram_addr=req_addr[i], ram_strobe=1.
  - No requester active: ram_strobe=0, ram_addr=0.
- Registered on clk:
  - req_ack <= one-hot(winner), or 0 when there is no grant.
  - On a grant: rr_ptr <= (winner+1) mod NUM_REQ. Otherwise rr_ptr is unchanged.
- Latency:
  - Grant in cycle N -> req_ack[i]=1 in cycle N+1, with req_rddata=ram_rddata in that same cycle.
  - req_rddata is a passthrough; it is undefined when no ack is high.
- Handshake:
  - A requester holds req_strobe and req_addr stable until it sees its ack.
  - req_strobe still high in the ack cycle counts as a new request, addressed by the current req_addr.
  - Back-to-back grants to the same requester happen only when no other requester is pending.
  - Dropping req_strobe before ack withdraws the request; no ack is produced.
- Simultaneous events:
  - cpu_busy and requests in the same cycle: the CPU wins and the requests wait. No ack is lost or duplicated.
- Fairness: with all NUM_REQ requesters continuously active and cpu_busy=0, grants cycle 0,1,2,0,... Each requester waits at most NUM_REQ-1 cycles.
- Wrap: rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-operation: an outstanding grant is discarded and no ack is emitted after rst_n rises. The requester keeps its strobe high and is re-served.
- cpu_hold is 0 when the optional feature is compiled out.

Optional Feature:
- Macro: VRAM_SCHED_STARVE_GUARD_EN.
- Enabled:
  - Each requester has a saturating wait counter of width $clog2(MAX_WAIT+1).
  - The counter increments each cycle req_strobe=1 without a grant. It clears on grant or when req_strobe=0.
  - cpu_hold <= 1 (registered) when any counter >= MAX_WAIT.
  - cpu_hold <= 0 in the cycle after every starved requester has been granted.
  - The block never overrides cpu_busy; it only asserts cpu_hold.
- Disabled: counters absent, cpu_hold tied 0.

Test Plan:
- Reset with req_strobe=3'b111 and rst_n=0 -> req_ack=0, ram_strobe=0. After release, the first ack goes to req 0 and ram_addr equals req_addr[0].
- All three requesters hold strobe with addresses 0x0010/0x0020/0x0030 and ram_rddata=word(addr) -> acks 001,010,100,001 on consecutive cycles, and each req_rddata equals the requester's word.
- req1 alone holds strobe for 4 cycles -> 4 consecutive acks to req1. ram_addr follows the changing req_addr 0x7FFF,0x0000,0x0001,0x0002.
- cpu_busy=1 for 5 cycles while req2 requests -> ram_strobe=0, no ack. req_ack=100 in the 2nd cycle after cpu_busy falls.
- rst_n pulsed low in the cycle after req0 is granted -> no ack to req0 after reset. req0 (strobe still high) is acked in the 2nd cycle after release.
- VRAM_SCHED_STARVE_GUARD_EN defined, MAX_WAIT=4, cpu_busy=1 continuously, req0 requesting -> cpu_hold=1 from cycle 5. The bench drops cpu_busy, req0 is granted, and cpu_hold=0 on the following cycle.
